mem_access: RTL and testbench

- Memory-stage access unit: sits between the EX/MEM register and the MEM/WB register.
- Issues data-memory requests (dmemREN/dmemWEN) to the dcache and holds them until dhit.
- Raises mem_stall to the hazard unit while a request is outstanding.
- Holds the returned load word stable until the MEM/WB register accepts it (en).

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/mem_access_link_reg.sv | 37 +++
 rtl/mem_access.sv | 129 ++++++++++++
 tb/tb_mem_access.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage access unit: opcodes, word type, access FSM states.
package mem_access_pkg;

  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [5:0] {
    ADDI = 6'b001000,
    LW   = 6'b100011,
    SW   = 6'b101011,
    LL   = 6'b110000,
    SC   = 6'b111000,
    HALT = 6'b111111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } memstate_t;

endpackage

// File: rtl/mem_access_link_reg.sv
// LL/SC reservation: one valid bit plus the word address reserved by the last LL.
module mem_access_link_reg #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_ll_done,
  input  logic              i_st_done,
  input  logic [WORD_W-1:0] i_addr,
  input  logic              i_ccinv,
  input  logic [WORD_W-1:0] i_snoop_addr,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_addr
);

  logic              r_valid;
  logic [WORD_W-1:0] r_addr;
  logic              w_kill;

  assign w_kill  = (i_ccinv && (i_snoop_addr == r_addr)) || (i_st_done && (i_addr == r_addr));
  assign o_valid = r_valid;
  assign o_addr  = r_addr;

  // A completing LL takes priority over an invalidate in the same cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_ll_done) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end else if (w_kill) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access unit: issues dcache requests, stalls until dhit, holds load data for MEM/WB.
// Optional LL/SC reservation tracking is built when LLSC_EN is defined.
//
// state | meaning
// IDLE  | no request outstanding; a request may issue and hit this cycle
// WAIT  | request issued, waiting for dhit
// HOLD  | access done but MEM/WB not advancing; result held, no request
module mem_access
  import mem_access_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_memRead,
  input  logic              in_memWrite,
  input  logic              in_halt,
  input  logic [5:0]        in_opcode,
  input  logic [WORD_W-1:0] in_aluout,
  input  logic [WORD_W-1:0] in_storeData,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
`ifdef LLSC_EN
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
`endif
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] out_readData,
  output logic              mem_stall
);

  localparam logic [WORD_W-1:0] ADDR_MASK = ~((WORD_W'(1) << ADDR_LSB) - WORD_W'(1));

  memstate_t         r_state;
  logic [WORD_W-1:0] r_hold_data;
  opcode_t           w_op;
  logic              w_is_sc;
  logic              w_sc_fail;
  logic              w_req;
  logic              w_issue;
  logic              w_done;
  logic [WORD_W-1:0] w_addr;
  logic [WORD_W-1:0] w_result;

  assign w_op     = opcode_t'(in_opcode);
  assign w_is_sc  = (w_op == SC);
  assign w_addr   = in_aluout & ADDR_MASK;
  assign w_result = w_is_sc ? WORD_W'(1) : dmemload;

`ifdef LLSC_EN
  logic              w_link_valid;
  logic [WORD_W-1:0] w_link_addr;
  logic              w_ll_done;
  logic              w_st_done;

  assign w_sc_fail = w_is_sc & in_memWrite & ~(w_link_valid && (w_link_addr == w_addr));
  assign w_ll_done = w_done & (w_op == LL) & in_memRead & ~in_memWrite;
  assign w_st_done = w_done & in_memWrite;

  mem_access_link_reg #(.WORD_W(WORD_W)) u_link_reg (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_ll_done   (w_ll_done),
    .i_st_done   (w_st_done),
    .i_addr      (w_addr),
    .i_ccinv     (ccinv),
    .i_snoop_addr(ccsnoopaddr),
    .o_valid     (w_link_valid),
    .o_addr      (w_link_addr)
  );
`else
  assign w_sc_fail = 1'b0;
`endif

  // nRST gates the request path so a reset drops it without waiting for a clock.
  assign w_req   = nRST & (in_memRead | in_memWrite) & ~in_halt & ~flush & ~w_sc_fail;
  assign w_issue = w_req & (r_state != HOLD);
  assign w_done  = w_issue & dhit;

  assign dmemWEN      = w_issue & in_memWrite;
  assign dmemREN      = w_issue & ~in_memWrite;
  assign mem_stall    = w_issue & ~dhit;
  assign dmemaddr     = nRST ? w_addr : '0;
  assign dmemstore    = nRST ? in_storeData : '0;
  assign out_readData = !nRST              ? '0 :
                        (r_state == HOLD)  ? r_hold_data :
                        w_done             ? w_result : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_hold_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue && !dhit) begin
            r_state <= WAIT;
          end else if (w_done && !en) begin
            r_state     <= HOLD;
            r_hold_data <= w_result;
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (dhit) begin
            if (en) begin
              r_state <= IDLE;
            end else begin
              r_state     <= HOLD;
              r_hold_data <= w_result;
            end
          end
        end
        HOLD: begin
          if (en || flush) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access; covers LL/SC reservation when LLSC_EN is defined.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, flush, in_memRead, in_memWrite, in_halt, dhit;
  logic [5:0]  in_opcode;
  logic [31:0] in_aluout, in_storeData, dmemload;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore, out_readData;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  mem_access dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .en          (en),
    .flush       (flush),
    .in_memRead  (in_memRead),
    .in_memWrite (in_memWrite),
    .in_halt     (in_halt),
    .in_opcode   (in_opcode),
    .in_aluout   (in_aluout),
    .in_storeData(in_storeData),
    .dhit        (dhit),
    .dmemload    (dmemload),
`ifdef LLSC_EN
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
`endif
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .out_readData(out_readData),
    .mem_stall   (mem_stall)
  );

  task automatic clear_inputs();
    en = 1'b1; flush = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0; in_halt = 1'b0;
    dhit = 1'b0; in_opcode = 6'(ADDI); in_aluout = '0; in_storeData = '0; dmemload = '0;
    ccinv = 1'b0; ccsnoopaddr = '0;
  endtask

  // Return to posedge+1, where all stimulus is applied.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    in_memRead = 1'b1; in_opcode = 6'(LW); in_aluout = 32'h104; dhit = 1'b1; dmemload = 32'h5555_AAAA;
    in_storeData = 32'h1111_2222;
    #3;
    n_vec++; if (dmemREN !== 1'b0) begin n_miss++; $display("FAIL rst_ren got %0b exp 0", dmemREN); end
    n_vec++; if (mem_stall !== 1'b0) begin n_miss++; $display("FAIL rst_stall got %0b exp 0", mem_stall); end
    n_vec++; if (out_readData !== 32'h0) begin n_miss++; $display("FAIL rst_out got %h exp 0", out_readData); end
    n_vec++; if (dmemaddr !== 32'h0 || dmemstore !== 32'h0) begin n_miss++; $display("FAIL rst_addr got %h/%h exp 0/0", dmemaddr, dmemstore); end
    tick();
    clear_inputs();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_lw_hit();
    in_memRead = 1'b1; in_opcode = 6'(LW); in_aluout = 32'h0000_0104; dhit = 1'b1;
    dmemload = 32'hDEAD_BEEF; en = 1'b1;
    #3;
    n_vec++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0) begin n_miss++; $display("FAIL lw_req got ren=%0b wen=%0b exp 1/0", dmemREN, dmemWEN); end
    n_vec++; if (dmemaddr !== 32'h104) begin n_miss++; $display("FAIL lw_addr got %h exp 00000104", dmemaddr); end
    n_vec++; if (mem_stall !== 1'b0) begin n_miss++; $display("FAIL lw_stall got %0b exp 0", mem_stall); end
    n_vec++; if (out_readData !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL lw_data got %h exp deadbeef", out_readData); end
    tick();
    clear_inputs();
    dmemload = 32'hCAFE_0000;
    #3;
    n_vec++; if (out_readData !== 32'h0 || dmemREN !== 1'b0) begin n_miss++; $display("FAIL lw_after got out=%h ren=%0b exp 0/0", out_readData, dmemREN); end
    tick();
  endtask

  task automatic test_sw_wait();
    in_memWrite = 1'b1; in_opcode = 6'(SW); in_aluout = 32'h0000_0203; in_storeData = 32'h0BAD_F00D;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #3;
      n_vec++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin n_miss++; $display("FAIL sw_wen[%0d] got wen=%0b ren=%0b exp 1/0", i, dmemWEN, dmemREN); end
      n_vec++; if (mem_stall !== (i < 3)) begin n_miss++; $display("FAIL sw_stall[%0d] got %0b exp %0b", i, mem_stall, (i < 3)); end
      n_vec++; if (dmemaddr !== 32'h200 || dmemstore !== 32'h0BAD_F00D) begin n_miss++; $display("FAIL sw_addr[%0d] got %h/%h exp 00000200/0badf00d", i, dmemaddr, dmemstore); end
      tick();
    end
    clear_inputs();
    #3;
    n_vec++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL sw_idle got wen=%0b stall=%0b exp 0/0", dmemWEN, mem_stall); end
    tick();
  endtask

  task automatic test_hold();
    in_memRead = 1'b1; in_opcode = 6'(LW); in_aluout = 32'h10; dhit = 1'b1;
    dmemload = 32'h1234_5678; en = 1'b0;
    #3;
    n_vec++; if (out_readData !== 32'h1234_5678 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL hold_hit got out=%h stall=%0b exp 12345678/0", out_readData, mem_stall); end
    tick();
    dhit = 1'b0; dmemload = 32'h0;
    for (int i = 0; i < 2; i++) begin
      en = (i == 1);
      #3;
      n_vec++; if (out_readData !== 32'h1234_5678) begin n_miss++; $display("FAIL hold_data[%0d] got %h exp 12345678", i, out_readData); end
      n_vec++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL hold_req[%0d] got ren=%0b stall=%0b exp 0/0", i, dmemREN, mem_stall); end
      tick();
    end
    clear_inputs();
    #3;
    n_vec++; if (out_readData !== 32'h0 || dmemREN !== 1'b0) begin n_miss++; $display("FAIL hold_exit got out=%h ren=%0b exp 0/0", out_readData, dmemREN); end
    tick();
    // A store that hits while MEM/WB is stalled must not be re-issued.
    in_memWrite = 1'b1; in_opcode = 6'(SW); in_aluout = 32'h300; dhit = 1'b1; en = 1'b0;
    #3;
    n_vec++; if (dmemWEN !== 1'b1) begin n_miss++; $display("FAIL hold_sw_issue got %0b exp 1", dmemWEN); end
    tick();
    dhit = 1'b0;
    #3;
    n_vec++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL hold_sw_reissue got wen=%0b stall=%0b exp 0/0", dmemWEN, mem_stall); end
    en = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    in_memRead = 1'b1; in_opcode = 6'(LW); in_aluout = 32'h50; en = 1'b1;
    tick();
    #3;
    n_vec++; if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin n_miss++; $display("FAIL rw_wait got ren=%0b stall=%0b exp 1/1", dmemREN, mem_stall); end
    #1 nRST = 1'b0;
    #1;
    n_vec++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL rw_drop got ren=%0b stall=%0b exp 0/0", dmemREN, mem_stall); end
    n_vec++; if (out_readData !== 32'h0) begin n_miss++; $display("FAIL rw_out got %h exp 0", out_readData); end
    tick();
    nRST = 1'b1;
    dhit = 1'b1; dmemload = 32'hAAAA_5555;
    #3;
    n_vec++; if (mem_stall !== 1'b0 || out_readData !== 32'hAAAA_5555) begin n_miss++; $display("FAIL rw_idle got stall=%0b out=%h exp 0/aaaa5555", mem_stall, out_readData); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_halt();
    in_memRead = 1'b1; in_halt = 1'b1; in_opcode = 6'(HALT); en = 1'b1;
    #3;
    n_vec++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL halt got ren=%0b stall=%0b exp 0/0", dmemREN, mem_stall); end
    tick();
    #3;
    n_vec++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL halt_next got ren=%0b stall=%0b exp 0/0", dmemREN, mem_stall); end
    clear_inputs();
    in_memWrite = 1'b1; flush = 1'b1; in_opcode = 6'(SW);
    #3;
    n_vec++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin n_miss++; $display("FAIL flush got wen=%0b stall=%0b exp 0/0", dmemWEN, mem_stall); end
    tick();
    clear_inputs();
    tick();
  endtask

`ifdef LLSC_EN
  task automatic test_llsc();
    in_memRead = 1'b1; in_opcode = 6'(LL); in_aluout = 32'h40; dhit = 1'b1; dmemload = 32'h77;
    #3;
    n_vec++; if (dmemREN !== 1'b1 || out_readData !== 32'h77) begin n_miss++; $display("FAIL ll_hit got ren=%0b out=%h exp 1/00000077", dmemREN, out_readData); end
    tick();
    clear_inputs(); ccinv = 1'b1; ccsnoopaddr = 32'h40;
    tick();
    clear_inputs(); in_memWrite = 1'b1; in_opcode = 6'(SC); in_aluout = 32'h40; in_storeData = 32'h5;
    #3;
    n_vec++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0 || out_readData !== 32'h0) begin n_miss++; $display("FAIL sc_inv got wen=%0b stall=%0b out=%h exp 0/0/0", dmemWEN, mem_stall, out_readData); end
    tick();
    clear_inputs(); in_memRead = 1'b1; in_opcode = 6'(LL); in_aluout = 32'h40; dhit = 1'b1;
    tick();
    clear_inputs(); in_memWrite = 1'b1; in_opcode = 6'(SC); in_aluout = 32'h40; in_storeData = 32'h5;
    #3;
    n_vec++; if (dmemWEN !== 1'b1 || mem_stall !== 1'b1) begin n_miss++; $display("FAIL sc_ok_wait got wen=%0b stall=%0b exp 1/1", dmemWEN, mem_stall); end
    tick();
    dhit = 1'b1; dmemload = 32'hFFFF_0000;
    #3;
    n_vec++; if (dmemWEN !== 1'b1 || out_readData !== 32'h1) begin n_miss++; $display("FAIL sc_ok_hit got wen=%0b out=%h exp 1/00000001", dmemWEN, out_readData); end
    tick();
    dhit = 1'b0;
    #3;
    n_vec++; if (dmemWEN !== 1'b0 || out_readData !== 32'h0) begin n_miss++; $display("FAIL sc_again got wen=%0b out=%h exp 0/0", dmemWEN, out_readData); end
    tick();
    clear_inputs(); in_memRead = 1'b1; in_opcode = 6'(LL); in_aluout = 32'h80; dhit = 1'b1;
    ccinv = 1'b1; ccsnoopaddr = 32'h80;
    tick();
    clear_inputs(); in_memWrite = 1'b1; in_opcode = 6'(SC); in_aluout = 32'h80; dhit = 1'b1;
    #3;
    n_vec++; if (dmemWEN !== 1'b1 || out_readData !== 32'h1) begin n_miss++; $display("FAIL ll_wins got wen=%0b out=%h exp 1/00000001", dmemWEN, out_readData); end
    tick();
    clear_inputs();
    tick();
  endtask
`else
  task automatic test_sc_plain();
    in_memRead = 1'b1; in_opcode = 6'(LL); in_aluout = 32'h44; dhit = 1'b1; dmemload = 32'h0000_0ABC;
    #3;
    n_vec++; if (dmemREN !== 1'b1 || out_readData !== 32'h0000_0ABC) begin n_miss++; $display("FAIL ll_as_lw got ren=%0b out=%h exp 1/00000abc", dmemREN, out_readData); end
    tick();
    clear_inputs(); in_memWrite = 1'b1; in_opcode = 6'(SC); in_aluout = 32'h45; dhit = 1'b1; dmemload = 32'h9999_9999;
    #3;
    n_vec++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== 32'h44) begin n_miss++; $display("FAIL sc_req got wen=%0b ren=%0b addr=%h exp 1/0/00000044", dmemWEN, dmemREN, dmemaddr); end
    n_vec++; if (out_readData !== 32'h1) begin n_miss++; $display("FAIL sc_result got %h exp 00000001", out_readData); end
    tick();
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    clear_inputs();
    nRST = 1'b0;
    #1;
    test_reset();
    test_lw_hit();
    test_sw_wait();
    test_hold();
    test_reset_mid_wait();
    test_halt();
`ifdef LLSC_EN
    test_llsc();
`else
    test_sc_plain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
